if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch and decode stages and buffers up to DEPTH fetched {pc, instr} pairs in a FIFO, so the fetch stage can run ahead while decode is stalled.
- Drives the decode-stage pc/instr registers, inserting zero bubbles when the queue is empty.
- Supports a pipeline flush for branch/exception redirects and uses the same stall-vector convention as the rest of the pipeline.

Parameters:
- PC_W, 32, width of pc field.
- INSTR_W, 32, width of instruction field.
- DEPTH, 4, FIFO entries; power of two, >=2.
- STALL_W, 6, width of pipeline stall vector.
- STAGE, 1, index of fetch stage in stall vector; decode is STAGE+1 (STAGE+1 < STALL_W).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low (`RstEnable` = 1'b0).
- stall  in  STALL_W  pipeline stall vector; bit = `StallEnable` (1) means stage held.
- flush  in  1  redirect: discard all buffered and output state.
- if_valid  in  1  fetch presents a valid pair.
- if_pc  in  PC_W  fetched pc.
- if_instr  in  INSTR_W  fetched instruction.
- if_ready  out  1  queue can accept; combinational = !full && !flush.
- id_pc  out  PC_W  registered pc to decode.
- id_instr  out  INSTR_W  registered instruction to decode.
- id_valid  out  1  registered; 1 = id_* holds a real instruction, 0 = bubble.
- count  out  $clog2(DEPTH+1)  registered number of buffered entries (excluding id_* register).

Behaviour:
- Reset (rst==0 at edge): id_pc=0, id_instr=0, id_valid=0, count=0, read/write pointers=0. Reset dominates flush and all traffic.
- push = if_valid && if_ready && stall[STAGE]==`StallDisable`.
- adv (decode accepts) = stall[STAGE+1]==`StallDisable`.
- Flush (rst==1, flush==1): next edge clears queue (count=0, pointers=0) and loads id_pc=0, id_instr=0, id_valid=0 regardless of stall. Same-cycle push is dropped.
- adv==1 with count>0: head entry moves to id_*, id_valid=1, read pointer increments mod DEPTH.
- adv==1, count==0, push==1: bypass; the pushed pair goes directly to id_*, id_valid=1, count stays 0. Latency fetch->decode is 1 cycle, matching the single-register behaviour.
- adv==1, count==0, push==0: bubble; id_pc=0, id_instr=0, id_valid=0.
- adv==0: id_* and id_valid hold.
- Fetch stalled while decode runs (stall[STAGE]=1, stall[STAGE+1]=0): the queue drains as above. Once empty, bubbles are inserted; this replaces the legacy "zero when IF stalled and ID not" rule.
- push==1 and not consumed by bypass: write at write pointer, pointer increments mod DEPTH.
- count update: +1 on a non-bypass push without a pop; -1 on a pop without a push; unchanged when both or neither.
- Full (count==DEPTH): if_ready=0, no push. A pop in the same cycle does not re-enable ready until the next cycle.
- Empty: no underflow; the bubble rule applies.
- Pointers wrap at DEPTH. count never exceeds DEPTH.
- No X propagation: a bubble drives all-zero payload.

Test Plan:
- Reset/bypass: hold rst=0 for 2 cycles -> all outputs 0. Release, push pc=0x100, instr=0x24010001, no stalls -> next cycle id_pc=0x100, id_instr=0x24010001, id_valid=1, count=0.
- Decode stall fill: stall=6'b000100, push 0x100,0x104,0x108,0x10C -> count=4, if_ready=0, id_* held. Push attempt 0x110 ignored. Release stall -> id_pc sequence 0x100,0x104,0x108,0x10C, then a bubble (id_valid=0, id_pc=0).
- Simultaneous push/pop: count=2, no stalls, continuous pushes -> count stays 2 and order is preserved across pointer wrap (>=DEPTH+2 entries streamed).
- Flush: count=3, assert flush with if_valid=1 pc=0x200 -> next edge count=0, id_valid=0, id_pc=0, 0x200 not enqueued. Next push 0x300 appears on id_* after 1 cycle.
- Fetch-only stall: stall=6'b000010 with count=2 -> two entries drained, then bubbles; if_valid ignored throughout.
- Reset mid-operation: count=3, stall active, assert rst=0 with flush=1 -> all outputs and count 0; after release the first push bypasses.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode buffer. Holds up to DEPTH {pc, instr} pairs
// so fetch can run ahead while decode is stalled, and drives the registered
// decode-stage pc/instr/valid. An empty queue with decode advancing lets a
// new fetch bypass straight into id_*, which keeps the fetch->decode latency
// at one cycle. With nothing to deliver, decode receives an all-zero bubble.
module if_id_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int STAGE   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INSTR_W-1:0]         if_instr,
  output logic                       if_ready,
  output logic [PC_W-1:0]            id_pc,
  output logic [INSTR_W-1:0]         id_instr,
  output logic                       id_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int   PTR_W         = $clog2(DEPTH);
  localparam int   CNT_W         = $clog2(DEPTH+1);
  localparam int   ENT_W         = PC_W + INSTR_W;
  localparam logic RST_ENABLE    = 1'b0;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; the id_* registers act as its registered read port.
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PC_W-1:0]    id_pc_reg, id_pc_next;
  logic [INSTR_W-1:0] id_instr_reg, id_instr_next;
  logic               id_valid_reg, id_valid_next;

  logic               full;
  logic               push;
  logic               adv;
  logic               pop;
  logic               bypass;
  logic               wr_en;
  logic [ENT_W-1:0]   head;
  logic               unused_stall_bits;

  // Only the fetch and decode bits of the stall vector matter here.
  assign unused_stall_bits = ^stall;

  assign full     = (count_reg == FULL_CNT);
  // Ready looks only at the registered count, so a pop while full does not
  // reopen the queue until the following cycle.
  assign if_ready = !full && !flush;
  assign push     = if_valid && if_ready && (stall[STAGE] == STALL_DISABLE);
  assign adv      = (stall[STAGE+1] == STALL_DISABLE);
  assign pop      = adv && (count_reg != '0);
  assign bypass   = adv && (count_reg == '0) && push;
  assign wr_en    = push && !bypass;
  assign head     = mem[rd_ptr_reg];

  // Next-state: flush clears everything, otherwise pop/bypass/bubble/hold.
  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    id_pc_next    = id_pc_reg;
    id_instr_next = id_instr_reg;
    id_valid_next = id_valid_reg;
    if (flush) begin
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
      id_pc_next    = '0;
      id_instr_next = '0;
      id_valid_next = 1'b0;
    end else begin
      if (pop) begin
        {id_pc_next, id_instr_next} = head;
        id_valid_next               = 1'b1;
        rd_ptr_next                 = rd_ptr_reg + PTR_W'(1);
      end else if (bypass) begin
        id_pc_next    = if_pc;
        id_instr_next = if_instr;
        id_valid_next = 1'b1;
      end else if (adv) begin
        id_pc_next    = '0;
        id_instr_next = '0;
        id_valid_next = 1'b0;
      end
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      id_pc_reg    <= '0;
      id_instr_reg <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      id_pc_reg    <= id_pc_next;
      id_instr_reg <= id_instr_next;
      id_valid_reg <= id_valid_next;
    end
  end

  // Entry write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if ((rst != RST_ENABLE) && wr_en) begin
      mem[wr_ptr_reg] <= {if_pc, if_instr};
    end
  end

  assign id_pc    = id_pc_reg;
  assign id_instr = id_instr_reg;
  assign id_valid = id_valid_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a hand-computed vector table walking the
// fill/drain/flush/reset scenarios, then random traffic compared against a
// queue-based reference model.
module tb_if_id_queue;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int STALL_W = 6;
  localparam int STAGE   = 1;
  localparam int CNT_W   = $clog2(DEPTH+1);

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000100;
  localparam logic [5:0] S_IF   = 6'b000010;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_ready;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_valid;
  logic [CNT_W-1:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  if_id_queue #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .STALL_W(STALL_W), .STAGE(STAGE)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [63:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  // Applies one clock of spec rules; returns the ready seen before the edge.
  task automatic model_step(input logic r, input logic [5:0] s, input logic f,
                            input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, output logic rdy);
    logic psh;
    logic dec;
    rdy = (m_q.size() < DEPTH) && !f;
    if (!r || f) begin
      m_q.delete();
      m_valid = 1'b0; m_pc = '0; m_instr = '0;
    end else begin
      psh = v && rdy && !s[STAGE];
      dec = !s[STAGE+1];
      if (dec) begin
        if (m_q.size() > 0) begin
          {m_pc, m_instr} = m_q.pop_front();
          m_valid = 1'b1;
          if (psh) m_q.push_back({pc, ins});
        end else if (psh) begin
          m_pc = pc; m_instr = ins; m_valid = 1'b1;
        end else begin
          m_pc = '0; m_instr = '0; m_valid = 1'b0;
        end
      end else if (psh) begin
        m_q.push_back({pc, ins});
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : 32'h24010001 + pc - 32'h100;
  endfunction

  // Drives one cycle; returns model ready and the DUT's pre-edge ready.
  task automatic drive(input logic r, input logic [5:0] s, input logic f,
                       input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       output logic m_rdy, output logic d_rdy);
    @(negedge clk);
    rst = r; stall = s; flush = f; if_valid = v; if_pc = pc; if_instr = ins;
    #1;
    d_rdy = if_ready;
    model_step(r, s, f, v, pc, ins, m_rdy);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        vld;
    logic [31:0] pc;
    int          e_rdy;   // -1: not compared
    logic        e_val;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [5:0] s, input logic f,
                              input logic v, input logic [31:0] pc, input int er,
                              input logic ev, input logic [31:0] ep, input int ec);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.vld = v; t.pc = pc;
    t.e_rdy = er; t.e_val = ev; t.e_pc = ep; t.e_cnt = ec;
    return t;
  endfunction

  initial begin
    logic m_rdy;
    logic d_rdy;
    vec_t t;
    logic [5:0]  rs;
    logic        rr, rf, rv;
    logic [31:0] rpc, rins;

    rst = 1'b0; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    m_valid = 1'b0; m_pc = '0; m_instr = '0;

    //           rst stall  fl vld pc          rdy val id_pc     cnt
    // reset, then single-cycle bypass
    tbl.push_back(mk(0, S_NONE, 0, 0, 32'h000, -1, 0, 32'h000, 0));
    tbl.push_back(mk(0, S_NONE, 0, 0, 32'h000,  1, 0, 32'h000, 0));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h100,  1, 1, 32'h100, 0));
    // decode stalled: fill to full, extra push refused
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h100,  1, 1, 32'h100, 1));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h104,  1, 1, 32'h100, 2));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h108,  1, 1, 32'h100, 3));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h10C,  1, 1, 32'h100, 4));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h110,  0, 1, 32'h100, 4));
    // release: pop while full keeps ready low this cycle, push refused
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h1F0,  0, 1, 32'h100, 3));
    tbl.push_back(mk(1, S_NONE, 0, 0, 32'h000,  1, 1, 32'h104, 2));
    tbl.push_back(mk(1, S_NONE, 0, 0, 32'h000,  1, 1, 32'h108, 1));
    tbl.push_back(mk(1, S_NONE, 0, 0, 32'h000,  1, 1, 32'h10C, 0));
    tbl.push_back(mk(1, S_NONE, 0, 0, 32'h000,  1, 0, 32'h000, 0));
    // build count=2, then stream through pointer wrap
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h120,  1, 0, 32'h000, 1));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h124,  1, 0, 32'h000, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h128,  1, 1, 32'h120, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h12C,  1, 1, 32'h124, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h130,  1, 1, 32'h128, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h134,  1, 1, 32'h12C, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h138,  1, 1, 32'h130, 2));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h13C,  1, 1, 32'h134, 2));
    // count=3 then flush with a push that must be dropped
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h140,  1, 1, 32'h134, 3));
    tbl.push_back(mk(1, S_NONE, 1, 1, 32'h200,  0, 0, 32'h000, 0));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h300,  1, 1, 32'h300, 0));
    // fetch-only stall drains two entries then bubbles
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h310,  1, 1, 32'h300, 1));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h314,  1, 1, 32'h300, 2));
    tbl.push_back(mk(1, S_IF,   0, 1, 32'h3F0,  1, 1, 32'h310, 1));
    tbl.push_back(mk(1, S_IF,   0, 1, 32'h3F4,  1, 1, 32'h314, 0));
    tbl.push_back(mk(1, S_IF,   0, 1, 32'h3F8,  1, 0, 32'h000, 0));
    tbl.push_back(mk(1, S_IF,   0, 1, 32'h3FC,  1, 0, 32'h000, 0));
    // reset mid-operation dominates flush, then bypass
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h400,  1, 0, 32'h000, 1));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h404,  1, 0, 32'h000, 2));
    tbl.push_back(mk(1, S_ID,   0, 1, 32'h408,  1, 0, 32'h000, 3));
    tbl.push_back(mk(0, S_ID,   1, 1, 32'h40C,  0, 0, 32'h000, 0));
    tbl.push_back(mk(1, S_NONE, 0, 1, 32'h500,  1, 1, 32'h500, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(t.rst, t.stall, t.flush, t.vld, t.pc, instr_of(t.pc), m_rdy, d_rdy);
      if (t.e_rdy >= 0) chk($sformatf("vec%0d if_ready", i), {63'd0, d_rdy}, 64'(t.e_rdy));
      chk($sformatf("vec%0d id_valid", i), {63'd0, id_valid}, {63'd0, t.e_val});
      chk($sformatf("vec%0d id_pc", i), {32'd0, id_pc}, {32'd0, t.e_pc});
      chk($sformatf("vec%0d id_instr", i), {32'd0, id_instr}, {32'd0, instr_of(t.e_pc)});
      chk($sformatf("vec%0d count", i), 64'(count), 64'(t.e_cnt));
      $display("vec %0d rst=%0b stall=%b flush=%0b vld=%0b pc=%h -> rdy=%0b id_valid=%0b id_pc=%h count=%0d",
               i, t.rst, t.stall, t.flush, t.vld, t.pc, d_rdy, id_valid, id_pc, count);
    end

    // ---------------- random traffic vs model ----------------
    for (int i = 0; i < 300; i++) begin
      rr   = ($urandom_range(63) != 0);
      rf   = ($urandom_range(15) == 0);
      rv   = ($urandom_range(3) != 0);
      rs   = 6'($urandom);
      rs[STAGE]   = ($urandom_range(3) == 0);
      rs[STAGE+1] = ($urandom_range(1) == 0);
      rpc  = $urandom;
      rins = $urandom;
      drive(rr, rs, rf, rv, rpc, rins, m_rdy, d_rdy);
      chk($sformatf("rnd%0d if_ready", i), {63'd0, d_rdy}, {63'd0, m_rdy});
      chk($sformatf("rnd%0d id_valid", i), {63'd0, id_valid}, {63'd0, m_valid});
      chk($sformatf("rnd%0d id_pc", i), {32'd0, id_pc}, {32'd0, m_pc});
      chk($sformatf("rnd%0d id_instr", i), {32'd0, id_instr}, {32'd0, m_instr});
      chk($sformatf("rnd%0d count", i), 64'(count), 64'(m_q.size()));
      $display("rnd %0d rst=%0b stall=%b flush=%0b vld=%0b -> rdy=%0b id_valid=%0b id_pc=%h count=%0d",
               i, rr, rs, rf, rv, d_rdy, id_valid, id_pc, count);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
